// File: rtl/alien_fire_scheduler_pkg.sv
// Shared sizes, tuning constants, FSM encoding and the cooldown reload helper
// for the alien fire scheduler.
package alien_fire_scheduler_pkg;

    localparam int NUM_ROWS      = 4;
    localparam int NUM_COLS      = 8;
    localparam int NUM_SLOTS     = 2;
    localparam int COOLDOWN_BASE = 40;
    localparam int COOLDOWN_MIN  = 12;
    localparam int SPEEDUP_SHIFT = 0;

    localparam int NUM_CELLS = NUM_ROWS * NUM_COLS;
    localparam int ROW_W     = $clog2(NUM_ROWS);
    localparam int COL_W     = $clog2(NUM_COLS);
    localparam int CNT_W     = $clog2(NUM_CELLS + 1);
    localparam int CELL_W    = $clog2(NUM_CELLS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2
    } fire_state_t;

    // Frames until the next shot: shrinks with kills, floored, plus 0..7 frames of jitter.
    function automatic logic [7:0] calc_reload(input logic [CNT_W-1:0] remaining,
                                               input logic [2:0]       jitter);
        logic signed [8:0] killed;
        logic signed [8:0] cd;
        logic [9:0]        sum;
        killed = $signed(9'(NUM_CELLS)) - $signed(9'(remaining));
        cd     = $signed(9'(COOLDOWN_BASE)) - (killed >>> SPEEDUP_SHIFT);
        if (cd < $signed(9'(COOLDOWN_MIN))) begin
            cd = $signed(9'(COOLDOWN_MIN));
        end
        sum = 10'($unsigned(cd)) + 10'(jitter);
        return (sum > 10'd255) ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/alien_fire_scheduler_column_bottom.sv
// Combinational lookup of the bottom-most live alien in one column of the grid.
module alien_column_bottom
    import alien_fire_scheduler_pkg::*;
(
    input  logic [NUM_CELLS-1:0] alive,
    input  logic [COL_W-1:0]     col,
    output logic                 found,
    output logic [ROW_W-1:0]     row
);

    logic [NUM_ROWS-1:0] col_bits;

    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
        assign col_bits[gi] = alive[CELL_W'(gi * NUM_COLS) + CELL_W'(col)];
    end

    // Higher row index is lower on screen, so the last hit wins.
    always_comb begin
        found = |col_bits;
        row   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (col_bits[r]) begin
                row = ROW_W'(r);
            end
        end
    end

endmodule

// File: rtl/alien_fire_scheduler.sv
// Chooses when and from which alien a shot is fired and which bullet slot carries it.
module alien_fire_scheduler
    import alien_fire_scheduler_pkg::*;
(
    input  logic                 pixel_clk,
    input  logic                 rst_n,
    input  logic                 fsync,
    input  logic                 enable,
    input  logic [NUM_CELLS-1:0] alien_alive,
    input  logic [CNT_W-1:0]     aliens_remaining,
    input  logic [15:0]          rnd,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_SLOTS-1:0] fire_slot,
    output logic [ROW_W-1:0]     fire_row,
    output logic [COL_W-1:0]     fire_col,
    output logic [7:0]           cooldown,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_SELECT = 2'(SELECT);
    localparam logic [1:0] S_ISSUE  = 2'(ISSUE);

    logic [1:0]           state_reg, state_next;
    logic [7:0]           cooldown_reg, cooldown_next;
    logic [COL_W-1:0]     col_ptr_reg, col_ptr_next;
    logic [COL_W-1:0]     scan_cnt_reg, scan_cnt_next;
    logic [ROW_W-1:0]     tgt_row_reg, tgt_row_next;
    logic [COL_W-1:0]     tgt_col_reg, tgt_col_next;
    logic [NUM_SLOTS-1:0] fire_slot_reg, fire_slot_next;
    logic [ROW_W-1:0]     fire_row_reg, fire_row_next;
    logic [COL_W-1:0]     fire_col_reg, fire_col_next;

    logic                 col_found;
    logic [ROW_W-1:0]     col_row;
    logic [7:0]           reload;
    logic [COL_W-1:0]     start_col;
    logic [CELL_W-1:0]    tgt_idx;
    logic                 tgt_alive;
    logic                 no_aliens;
    logic [NUM_SLOTS-1:0] free_slots;
    logic [NUM_SLOTS-1:0] lowest_free;

    alien_column_bottom u_column_bottom (
        .alive (alien_alive),
        .col   (col_ptr_reg),
        .found (col_found),
        .row   (col_row)
    );

    assign reload      = calc_reload(aliens_remaining, rnd[2:0]);
    assign start_col   = COL_W'(16'(rnd[11:8]) % 16'(NUM_COLS));
    assign tgt_idx     = CELL_W'(tgt_row_reg) * CELL_W'(NUM_COLS) + CELL_W'(tgt_col_reg);
    assign tgt_alive   = alien_alive[tgt_idx];
    assign no_aliens   = (aliens_remaining == '0);
    assign free_slots  = ~slot_busy;
    // Two's-complement trick isolates the lowest set bit.
    assign lowest_free = free_slots & (~free_slots + NUM_SLOTS'(1));

    always_comb begin
        state_next     = state_reg;
        cooldown_next  = cooldown_reg;
        col_ptr_next   = col_ptr_reg;
        scan_cnt_next  = scan_cnt_reg;
        tgt_row_next   = tgt_row_reg;
        tgt_col_next   = tgt_col_reg;
        fire_slot_next = '0;
        fire_row_next  = fire_row_reg;
        fire_col_next  = fire_col_reg;

        if (!enable) begin
            state_next    = S_IDLE;
            cooldown_next = reload;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cooldown_reg == 8'd0) begin
                        if (!no_aliens) begin
                            state_next    = S_SELECT;
                            col_ptr_next  = start_col;
                            scan_cnt_next = '0;
                        end
                    end else if (fsync) begin
                        cooldown_next = cooldown_reg - 8'd1;
                    end
                end
                S_SELECT: begin
                    if (no_aliens) begin
                        state_next    = S_IDLE;
                        cooldown_next = reload;
                    end else if (col_found) begin
                        tgt_row_next = col_row;
                        tgt_col_next = col_ptr_reg;
                        state_next   = S_ISSUE;
                    end else if (scan_cnt_reg == COL_W'(NUM_COLS - 1)) begin
                        state_next    = S_IDLE;
                        cooldown_next = reload;
                    end else begin
                        col_ptr_next  = (col_ptr_reg == COL_W'(NUM_COLS - 1)) ? '0
                                                                             : col_ptr_reg + 1'b1;
                        scan_cnt_next = scan_cnt_reg + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (no_aliens) begin
                        state_next    = S_IDLE;
                        cooldown_next = reload;
                    end else if (!tgt_alive) begin
                        // Target died while waiting: rescan its column for the next one up.
                        state_next    = S_SELECT;
                        col_ptr_next  = tgt_col_reg;
                        scan_cnt_next = '0;
                    end else if (|free_slots) begin
                        fire_slot_next = lowest_free;
                        fire_row_next  = tgt_row_reg;
                        fire_col_next  = tgt_col_reg;
                        state_next     = S_IDLE;
                        cooldown_next  = reload;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cooldown_reg  <= 8'(COOLDOWN_BASE);
            col_ptr_reg   <= '0;
            scan_cnt_reg  <= '0;
            tgt_row_reg   <= '0;
            tgt_col_reg   <= '0;
            fire_slot_reg <= '0;
            fire_row_reg  <= '0;
            fire_col_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cooldown_reg  <= cooldown_next;
            col_ptr_reg   <= col_ptr_next;
            scan_cnt_reg  <= scan_cnt_next;
            tgt_row_reg   <= tgt_row_next;
            tgt_col_reg   <= tgt_col_next;
            fire_slot_reg <= fire_slot_next;
            fire_row_reg  <= fire_row_next;
            fire_col_reg  <= fire_col_next;
        end
    end

    assign fire_slot = fire_slot_reg;
    assign fire_row  = fire_row_reg;
    assign fire_col  = fire_col_reg;
    assign cooldown  = cooldown_reg;
    assign state_dbg = state_reg;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Self-checking bench: reload table, scripted firing sequences and a strobe scoreboard.
module tb_alien_fire_scheduler;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic        fsync;
    logic        enable;
    logic [31:0] alien_alive;
    logic [5:0]  aliens_remaining;
    logic [15:0] rnd;
    logic [1:0]  slot_busy;
    logic [1:0]  fire_slot;
    logic [1:0]  fire_row;
    logic [2:0]  fire_col;
    logic [7:0]  cooldown;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] slot;
        logic [1:0] row;
        logic [2:0] col;
    } fire_t;
    fire_t exp_q[$];

    typedef struct {
        logic [5:0] remaining;
        logic [2:0] jitter;
        logic [7:0] exp_cd;
    } reload_vec_t;

    always #5 pixel_clk = ~pixel_clk;

    alien_fire_scheduler dut (
        .pixel_clk        (pixel_clk),
        .rst_n            (rst_n),
        .fsync            (fsync),
        .enable           (enable),
        .alien_alive      (alien_alive),
        .aliens_remaining (aliens_remaining),
        .rnd              (rnd),
        .slot_busy        (slot_busy),
        .fire_slot        (fire_slot),
        .fire_row         (fire_row),
        .fire_col         (fire_col),
        .cooldown         (cooldown),
        .state_dbg        (state_dbg)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_reload(input int remaining, input int jitter);
        int cd;
        cd = 40 - (32 - remaining);
        if (cd < 12) cd = 12;
        cd = cd + jitter;
        return (cd > 255) ? 255 : cd;
    endfunction

    // Strobe scoreboard: every nonzero fire_slot cycle must match the next expected shot.
    always @(negedge pixel_clk) begin
        if (rst_n === 1'b1 && fire_slot != 2'b00) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got slot=%b row=%0d col=%0d, expected none",
                         fire_slot, fire_row, fire_col);
            end else begin
                fire_t e;
                e = exp_q.pop_front();
                $display("shot slot=%b row=%0d col=%0d (exp slot=%b row=%0d col=%0d)",
                         fire_slot, fire_row, fire_col, e.slot, e.row, e.col);
                check("strobe_slot", int'(fire_slot), int'(e.slot));
                check("strobe_row", int'(fire_row), int'(e.row));
                check("strobe_col", int'(fire_col), int'(e.col));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_to_zero(output int n);
        n = 0;
        while (cooldown != 8'd0 && n < 300) begin
            fsync = 1'b1;
            @(negedge pixel_clk);
            fsync = 1'b0;
            n++;
            if (cooldown == 8'd0) break;
            @(negedge pixel_clk);
        end
        check("cooldown_expired", int'(cooldown), 0);
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        int n = 0;
        while (state_dbg != st && n < budget) begin
            @(negedge pixel_clk);
            n++;
        end
        check(name, int'(state_dbg), int'(st));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge pixel_clk);
            n++;
        end
        check("expected_shot_seen", exp_q.size(), 0);
    endtask

    initial begin
        reload_vec_t vecs[11];
        int pulses;
        int sel_cycles;

        vecs[0]  = '{6'd32, 3'd0, 8'd40};
        vecs[1]  = '{6'd32, 3'd7, 8'd47};
        vecs[2]  = '{6'd2,  3'd0, 8'd12};
        vecs[3]  = '{6'd2,  3'd3, 8'd15};
        vecs[4]  = '{6'd20, 3'd0, 8'd28};
        vecs[5]  = '{6'd0,  3'd5, 8'd17};
        vecs[6]  = '{6'd28, 3'd2, 8'd38};
        vecs[7]  = '{6'd5,  3'd1, 8'd14};
        vecs[8]  = '{6'd4,  3'd0, 8'd12};
        vecs[9]  = '{6'd3,  3'd6, 8'd18};
        vecs[10] = '{6'd40, 3'd1, 8'd49};

        rst_n = 1'b0;
        fsync = 1'b0;
        enable = 1'b1;
        alien_alive = '1;
        aliens_remaining = 6'd32;
        rnd = 16'h0000;
        slot_busy = 2'b00;
        repeat (3) @(negedge pixel_clk);

        check("reset_state", int'(state_dbg), int'(ST_IDLE));
        check("reset_cooldown", int'(cooldown), 40);
        check("reset_fire_slot", int'(fire_slot), 0);
        check("reset_fire_row", int'(fire_row), 0);
        check("reset_fire_col", int'(fire_col), 0);
        rst_n = 1'b1;
        @(negedge pixel_clk);

        // Full grid, column 0, 40 frames of cooldown.
        exp_q.push_back('{2'b01, 2'd3, 3'd0});
        pulse_to_zero(pulses);
        check("t1_pulse_count", pulses, 40);
        check("t1_idle_at_zero", int'(state_dbg), int'(ST_IDLE));
        @(negedge pixel_clk);
        check("t1_select", int'(state_dbg), int'(ST_SELECT));
        @(negedge pixel_clk);
        check("t1_issue", int'(state_dbg), int'(ST_ISSUE));
        @(negedge pixel_clk);
        check("t1_fire_slot", int'(fire_slot), 1);
        check("t1_back_idle", int'(state_dbg), int'(ST_IDLE));
        check("t1_reload", int'(cooldown), model_reload(32, 0));
        @(negedge pixel_clk);
        check("t1_strobe_one_cycle", int'(fire_slot), 0);
        check("t1_row_hold", int'(fire_row), 3);
        drain(5);

        // Column 3 dead: scan wraps forward to column 4.
        for (int r = 0; r < 4; r++) alien_alive[r*8+3] = 1'b0;
        aliens_remaining = 6'd28;
        rnd = 16'h0300;
        exp_q.push_back('{2'b01, 2'd3, 3'd4});
        pulse_to_zero(pulses);
        @(negedge pixel_clk);
        check("t2_select_a", int'(state_dbg), int'(ST_SELECT));
        @(negedge pixel_clk);
        check("t2_select_b", int'(state_dbg), int'(ST_SELECT));
        @(negedge pixel_clk);
        check("t2_issue", int'(state_dbg), int'(ST_ISSUE));
        @(negedge pixel_clk);
        check("t2_fire_col", int'(fire_col), 4);
        check("t2_reload", int'(cooldown), model_reload(28, 0));
        drain(5);

        // All slots busy: hold in ISSUE, then slot 1 frees up.
        rnd = 16'h0000;
        slot_busy = 2'b11;
        exp_q.push_back('{2'b10, 2'd3, 3'd0});
        pulse_to_zero(pulses);
        wait_state(ST_ISSUE, 10, "t3_reach_issue");
        for (int i = 0; i < 100; i++) begin
            @(negedge pixel_clk);
            check("t3_hold_no_strobe", int'(fire_slot), 0);
            check("t3_hold_issue", int'(state_dbg), int'(ST_ISSUE));
        end
        slot_busy = 2'b01;
        @(negedge pixel_clk);
        check("t3_fire_slot1", int'(fire_slot), 2);
        drain(5);

        // Target (3,5) killed while waiting: rescan column 5, fire from (2,5).
        rnd = 16'h0500;
        slot_busy = 2'b11;
        exp_q.push_back('{2'b01, 2'd2, 3'd5});
        pulse_to_zero(pulses);
        wait_state(ST_ISSUE, 10, "t5a_reach_issue");
        alien_alive[29] = 1'b0;
        aliens_remaining = 6'd27;
        @(negedge pixel_clk);
        check("t5a_back_select", int'(state_dbg), int'(ST_SELECT));
        @(negedge pixel_clk);
        check("t5a_issue_again", int'(state_dbg), int'(ST_ISSUE));
        slot_busy = 2'b00;
        drain(5);

        // Whole column 5 killed while waiting: fire moves to column 6.
        slot_busy = 2'b11;
        exp_q.push_back('{2'b01, 2'd3, 3'd6});
        pulse_to_zero(pulses);
        wait_state(ST_ISSUE, 10, "t5b_reach_issue");
        for (int r = 0; r < 3; r++) alien_alive[r*8+5] = 1'b0;
        aliens_remaining = 6'd24;
        @(negedge pixel_clk);
        check("t5b_select_a", int'(state_dbg), int'(ST_SELECT));
        @(negedge pixel_clk);
        check("t5b_select_b", int'(state_dbg), int'(ST_SELECT));
        @(negedge pixel_clk);
        check("t5b_issue", int'(state_dbg), int'(ST_ISSUE));
        slot_busy = 2'b00;
        drain(5);

        // Empty grid with a nonzero count: full 8-column scan, then give up silently.
        alien_alive = '0;
        aliens_remaining = 6'd5;
        rnd = 16'h0200;
        pulse_to_zero(pulses);
        sel_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pixel_clk);
            if (state_dbg == ST_SELECT) sel_cycles++;
            else if (sel_cycles > 0) break;
        end
        check("scan_len", sel_cycles, 8);
        check("scan_idle", int'(state_dbg), int'(ST_IDLE));
        check("scan_reload", int'(cooldown), model_reload(5, 0));

        // Reload table observed through enable-low recomputation.
        enable = 1'b0;
        for (int i = 0; i < 11; i++) begin
            aliens_remaining = vecs[i].remaining;
            rnd = {13'd0, vecs[i].jitter};
            @(negedge pixel_clk);
            $display("reload remaining=%0d jitter=%0d cooldown=%0d exp=%0d",
                     vecs[i].remaining, vecs[i].jitter, cooldown, vecs[i].exp_cd);
            check("reload_table", int'(cooldown), int'(vecs[i].exp_cd));
        end

        // enable dropped exactly when cooldown hits zero: never fires.
        enable = 1'b1;
        alien_alive = '1;
        aliens_remaining = 6'd32;
        rnd = 16'h0000;
        pulse_to_zero(pulses);
        enable = 1'b0;
        for (int i = 0; i < 30; i++) begin
            fsync = (i % 4 == 0);
            @(negedge pixel_clk);
            check("dis_idle", int'(state_dbg), int'(ST_IDLE));
        end
        fsync = 1'b0;
        check("dis_reload", int'(cooldown), 40);

        // Asynchronous reset mid-SELECT.
        enable = 1'b1;
        pulse_to_zero(pulses);
        @(negedge pixel_clk);
        check("rst_pre_select", int'(state_dbg), int'(ST_SELECT));
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_state", int'(state_dbg), int'(ST_IDLE));
        check("rst_async_slot", int'(fire_slot), 0);
        check("rst_async_cooldown", int'(cooldown), 40);
        @(negedge pixel_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge pixel_clk);
        check("rst_release_cooldown", int'(cooldown), 40);
        check("rst_release_state", int'(state_dbg), int'(ST_IDLE));

        // No aliens remaining: cooldown may expire but nothing is ever selected.
        aliens_remaining = 6'd0;
        rnd = 16'h0005;
        pulse_to_zero(pulses);
        for (int i = 0; i < 20; i++) begin
            @(negedge pixel_clk);
            check("zero_aliens_idle", int'(state_dbg), int'(ST_IDLE));
        end
        check("zero_aliens_cooldown", int'(cooldown), 0);

        repeat (2) @(negedge pixel_clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
